regread_arbiter: RTL and testbench

- Shares the CPU's single 16-entry x 16-bit register-file read port (the 16:1 select mux) among NREQ requesters (decode, ALU operand fetch, debug, DMA).
- Each cycle it grants one requester by round-robin and drives the mux select from that requester's address.
- It registers the mux output and returns it to the granted requester one cycle later.
- Supports a lock for bounded back-to-back ownership (burst operand fetch).

---
 rtl/regread_arbiter.sv | 135 +++++++++++++
 tb/tb_regread_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regread_arbiter.sv
// Round-robin arbiter for the shared 16x16 register-file read port, with bounded lock bursts.
// Optional per-requester grant counters are enabled by defining REGREAD_GRANT_COUNT_EN.
module regread_arbiter #(
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [4*NREQ-1:0]    addr,
   input  logic [NREQ-1:0]      lock,
   output logic [NREQ-1:0]      gnt,
   output logic [3:0]           sel,
   input  logic [15:0]          mux_out,
   output logic [15:0]          rdata,
   output logic [NREQ-1:0]      rvalid,
   output logic                 busy
`ifdef REGREAD_GRANT_COUNT_EN
   ,
   input  logic                 cnt_clear,
   output logic [16*NREQ-1:0]   gnt_count
`endif
);

   localparam int          PW = $clog2(NREQ);
   localparam int unsigned N  = NREQ;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state, state_d;
   logic [PW-1:0]   ptr, ptr_d;
   logic [PW-1:0]   owner, owner_d;
   logic [3:0]      burst_cnt, burst_cnt_d;
   logic            win_vld;
   logic [PW-1:0]   win;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
      return (32'(i) == N - 1) ? '0 : PW'(32'(i) + 32'd1);
   endfunction

   // State register and registered read return
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         owner     <= '0;
         burst_cnt <= '0;
         rdata     <= '0;
         rvalid    <= '0;
      end else begin
         state     <= state_d;
         ptr       <= ptr_d;
         owner     <= owner_d;
         burst_cnt <= burst_cnt_d;
         rvalid    <= gnt;
         if (|gnt) rdata <= mux_out;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state;
      ptr_d       = ptr;
      owner_d     = owner;
      burst_cnt_d = burst_cnt;
      case (state)
         IDLE: begin
            if (win_vld) begin
               if (lock[win]) begin
                  state_d     = LOCKED;
                  owner_d     = win;
                  burst_cnt_d = 4'd1;
               end else begin
                  ptr_d = wrap_inc(win);
               end
            end
         end
         LOCKED: begin
            // Budget is consumed every locked cycle, granted or not
            if (!lock[owner] || burst_cnt == 4'(MAX_BURST)) begin
               state_d     = IDLE;
               ptr_d       = wrap_inc(owner);
               burst_cnt_d = '0;
            end else begin
               burst_cnt_d = burst_cnt + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: winner selection, grant and mux select
   always_comb begin
      logic [PW-1:0] cand;
      win_vld = 1'b0;
      win     = '0;
      cand    = '0;
      if (!reset) begin
         if (state == IDLE) begin
            for (int unsigned k = 0; k < N; k++) begin
               cand = PW'((32'(ptr) + k) % N);
               if (!win_vld && req[cand]) begin
                  win_vld = 1'b1;
                  win     = cand;
               end
            end
         end else if (req[owner]) begin
            win_vld = 1'b1;
            win     = owner;
         end
      end
      gnt = '0;
      sel = '0;
      if (win_vld) begin
         gnt[win] = 1'b1;
         sel      = addr[4*win +: 4];
      end
   end

   assign busy = (state == LOCKED);

`ifdef REGREAD_GRANT_COUNT_EN
   for (genvar g = 0; g < NREQ; g++) begin : g_cnt
      logic [15:0] cnt;
      always_ff @(posedge clk) begin
         if (reset || cnt_clear)
            cnt <= '0;
         else if (gnt[g] && cnt != '1)
            cnt <= cnt + 16'd1;
      end
      assign gnt_count[16*g +: 16] = cnt;
   end
`endif

endmodule

// File: tb/tb_regread_arbiter.sv
// Self-checking bench for regread_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin/lock model.
module tb_regread_arbiter;
   localparam int N  = 4;
   localparam int MB = 4;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req;
   logic [4*N-1:0]  addr;
   logic [N-1:0]    lock;
   logic [N-1:0]    gnt;
   logic [3:0]      sel;
   logic [15:0]     mux_out;
   logic [15:0]     rdata;
   logic [N-1:0]    rvalid;
   logic            busy;
`ifdef REGREAD_GRANT_COUNT_EN
   logic            cnt_clear;
   logic [16*N-1:0] gnt_count;
`endif

   regread_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset), .req(req), .addr(addr), .lock(lock),
      .gnt(gnt), .sel(sel), .mux_out(mux_out), .rdata(rdata),
      .rvalid(rvalid), .busy(busy)
`ifdef REGREAD_GRANT_COUNT_EN
      , .cnt_clear(cnt_clear), .gnt_count(gnt_count)
`endif
   );

   logic [15:0] rf [16];
   always_comb mux_out = rf[sel];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;

   // model state
   bit          m_locked;
   int          m_ptr, m_owner, m_cnt, m_win;
   int          m_gc [N];
   logic [N-1:0]  exp_gnt, exp_rvalid;
   logic [3:0]    exp_sel;
   logic [15:0]   exp_rdata;
   logic          exp_busy;
   logic [N-1:0]  s_gnt;
   logic [3:0]    s_sel;

   task automatic model_eval();
      m_win = -1;
      if (!reset) begin
         if (!m_locked) begin
            for (int k = 0; k < N; k++)
               if (m_win < 0 && req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
         end else if (req[m_owner]) begin
            m_win = m_owner;
         end
      end
      exp_gnt = (m_win >= 0) ? N'(1 << m_win) : '0;
      exp_sel = (m_win >= 0) ? addr[4*m_win +: 4] : 4'd0;
   endtask

   task automatic model_update();
      if (reset) begin
         m_locked = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
         exp_rvalid = '0; exp_rdata = '0;
      end else begin
         exp_rvalid = exp_gnt;
         if (m_win >= 0) exp_rdata = rf[exp_sel];
         if (!m_locked) begin
            if (m_win >= 0) begin
               if (lock[m_win]) begin
                  m_locked = 1; m_owner = m_win; m_cnt = 1;
               end else begin
                  m_ptr = (m_win + 1) % N;
               end
            end
         end else if (!lock[m_owner] || m_cnt == MB) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N;
         end else begin
            m_cnt++;
         end
      end
      exp_busy = m_locked;
`ifdef REGREAD_GRANT_COUNT_EN
      for (int i = 0; i < N; i++) begin
         if (reset || cnt_clear) m_gc[i] = 0;
         else if (m_win == i && m_gc[i] < 65535) m_gc[i]++;
      end
`endif
   endtask

   // Sample combinational outputs before the edge, advance model, land 1 after the edge
   task automatic cycle();
      #2;
      s_gnt = gnt;
      s_sel = sel;
      model_eval();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; lock = '0;
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 4'b1111; lock = 4'b1111; addr = 16'hABCD;
      cycle();
      checks++; if (s_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", s_gnt); end
      checks++; if (s_sel !== 4'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", s_sel); end
      cycle();
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid got %b exp 0000", rvalid); end
      checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", rdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      reset = 1'b0; req = '0; lock = '0;
   endtask

   task automatic test_single();
      do_reset();
      rf[5] = 16'h1234;
      req = 4'b0001; addr = 16'h0005; lock = '0;
      cycle();
      checks++; if (s_gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", s_gnt); end
      checks++; if (s_sel !== 4'd5) begin errors++; $display("FAIL single_sel got %0d exp 5", s_sel); end
      checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL single_rvalid got %b exp 0001", rvalid); end
      checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL single_rdata got %h exp 1234", rdata); end
      req = '0;
      cycle();
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL idle_rvalid got %b exp 0000", rvalid); end
      checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL idle_rdata_hold got %h exp 1234", rdata); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] e;
      do_reset();
      req = 4'b1111; lock = '0; addr = 16'h3210;
      for (int i = 0; i < N; i++) begin
         cycle();
         e = N'(1 << i);
         checks++; if (s_gnt !== e) begin errors++; $display("FAIL rr_gnt%0d got %b exp %b", i, s_gnt, e); end
         checks++; if (s_sel !== 4'(i)) begin errors++; $display("FAIL rr_sel%0d got %0d exp %0d", i, s_sel, i); end
      end
      cycle();
      checks++; if (s_gnt !== 4'b0001) begin errors++; $display("FAIL rr_wrap got %b exp 0001", s_gnt); end
      req = '0;
   endtask

   task automatic test_lock_release();
      do_reset();
      req = 4'b0101; lock = 4'b0001; addr = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) lock = '0;
         cycle();
         checks++; if (s_gnt !== 4'b0001) begin errors++; $display("FAIL lock_gnt%0d got %b exp 0001", i, s_gnt); end
         checks++; if (busy !== (i < 2)) begin errors++; $display("FAIL lock_busy%0d got %b exp %b", i, busy, (i < 2)); end
      end
      cycle();
      checks++; if (s_gnt !== 4'b0100) begin errors++; $display("FAIL lock_next got %b exp 0100", s_gnt); end
      req = '0;
   endtask

   task automatic test_forced_release();
      do_reset();
      req = 4'b1010; lock = 4'b0010; addr = 16'h0000;
      for (int i = 0; i < MB + 1; i++) begin
         cycle();
         checks++; if (s_gnt !== 4'b0010) begin errors++; $display("FAIL forced_gnt%0d got %b exp 0010", i, s_gnt); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL forced_busy got %b exp 0", busy); end
      cycle();
      checks++; if (s_gnt !== 4'b1000) begin errors++; $display("FAIL forced_next got %b exp 1000", s_gnt); end
      req = '0; lock = '0;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req = 4'b0001; lock = 4'b0001; addr = 16'h0007;
      cycle();
      cycle();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_locked got %b exp 1", busy); end
      reset = 1'b1;
      cycle();
      checks++; if (s_gnt !== 4'b0000) begin errors++; $display("FAIL midrst_gnt got %b exp 0000", s_gnt); end
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL midrst_rvalid got %b exp 0000", rvalid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
      checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL midrst_rdata got %h exp 0000", rdata); end
      reset = 1'b0; req = 4'b0100; lock = '0; addr = 16'h0900;
      cycle();
      checks++; if (s_gnt !== 4'b0100) begin errors++; $display("FAIL midrst_after got %b exp 0100", s_gnt); end
      req = '0;
   endtask

`ifdef REGREAD_GRANT_COUNT_EN
   task automatic test_counters();
      do_reset();
      req = 4'b0100; lock = '0; addr = 16'h0000;
      repeat (3) cycle();
      checks++; if (gnt_count[47:32] !== 16'd3) begin errors++; $display("FAIL cnt_three got %0d exp 3", gnt_count[47:32]); end
      cnt_clear = 1'b1;
      cycle();
      cnt_clear = 1'b0;
      checks++; if (gnt_count[47:32] !== 16'd0) begin errors++; $display("FAIL cnt_clear got %0d exp 0", gnt_count[47:32]); end
      req = '0;
   endtask
`endif

   task automatic test_random();
      do_reset();
      s_gnt = '0;
      for (int c = 0; c < 500; c++) begin
         for (int j = 0; j < 16; j++) rf[j] = 16'($urandom);
         for (int i = 0; i < N; i++) begin
            if (!req[i] || s_gnt[i]) begin
               req[i] = ($urandom_range(0, 2) != 0);
               addr[4*i +: 4] = 4'($urandom_range(0, 15));
            end
         end
         lock  = N'($urandom);
         reset = ($urandom_range(0, 99) == 0);
`ifdef REGREAD_GRANT_COUNT_EN
         cnt_clear = ($urandom_range(0, 49) == 0);
`endif
         cycle();
         checks++; if (s_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c%0d got %b exp %b", c, s_gnt, exp_gnt); end
         checks++; if (s_sel !== exp_sel) begin errors++; $display("FAIL rnd_sel c%0d got %0d exp %0d", c, s_sel, exp_sel); end
         checks++; if (rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid c%0d got %b exp %b", c, rvalid, exp_rvalid); end
         checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata c%0d got %h exp %h", c, rdata, exp_rdata); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy c%0d got %b exp %b", c, busy, exp_busy); end
`ifdef REGREAD_GRANT_COUNT_EN
         for (int i = 0; i < N; i++) begin
            checks++;
            if (gnt_count[16*i +: 16] !== 16'(m_gc[i])) begin
               errors++; $display("FAIL rnd_cnt%0d c%0d got %0d exp %0d", i, c, gnt_count[16*i +: 16], m_gc[i]);
            end
         end
`endif
      end
      reset = 1'b0; req = '0; lock = '0;
   endtask

   initial begin
      reset = 1'b1; req = '0; lock = '0; addr = '0;
`ifdef REGREAD_GRANT_COUNT_EN
      cnt_clear = 1'b0;
`endif
      for (int j = 0; j < 16; j++) rf[j] = 16'(j * 16'h0101);
      m_locked = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) m_gc[i] = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_lock_release();
      test_forced_release();
      test_reset_mid_burst();
`ifdef REGREAD_GRANT_COUNT_EN
      test_counters();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
